serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Round-robin arbiter and sequencer sharing one `serial_tx` UART transmitter between `NUM_REQ` byte-stream requesters. It grants the transmitter to one requester per packet, so packets are never interleaved. It issues one `new_data` pulse per byte and paces bytes off the transmitter's `busy`. It also passes an external flow-control hold onto the transmitter's `block` input.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_TIMEOUT`, 1000: idle cycles allowed mid-packet with `req_valid` low before the grant is dropped; must be ≥ 1.
- `CTR_SIZE`, `$clog2(GAP_TIMEOUT+1)`: gap counter width, derived.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i has a byte on its `req_data` slice.
- `req_data`  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i]; held stable while valid until ready.
- `req_last`  in  NUM_REQ  the offered byte is the last of its packet.
- `req_ready`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- `grant`  out  NUM_REQ  one-hot owner of the transmitter, or all zero.
- `hold`  in  1  flow-control pause, e.g. CTS deasserted.
- `tx_new_data`  out  1  to `serial_tx.new_data`.
- `tx_data`  out  8  to `serial_tx.data`.
- `tx_block`  out  1  to `serial_tx.block`; equals registered `hold`.
- `tx_busy`  in  1  from `serial_tx.busy`.

## Operation
- States:
  - `ARB`: no owner.
  - `ISSUE`: new_data cycle.
  - `WAIT_START`: wait for busy to rise.
  - `WAIT_DONE`: wait for busy to fall.
  - `NEXT`: owner keeps the grant and waits for its next byte.
- Reset values: state `ARB`; `grant`=0; `req_ready`=0; `tx_new_data`=0; `tx_data`=0; `tx_block`=0; round-robin pointer `ptr`=NUM_REQ-1; gap counter=0.
- `ARB`:
  - Blocked if `hold_q`=1 or `tx_busy`=1.
  - Otherwise choose the first i with `req_valid[i]`, searching from `ptr+1` and wrapping modulo NUM_REQ.
  - Then: `grant`←onehot(i), `ptr`←i, `tx_data`←byte i, `last_q`←`req_last[i]`, go to `ISSUE`.
- `ISSUE`:
  - `tx_new_data`=1 and `req_ready[owner]`=1 for exactly this cycle.
  - Go to `WAIT_START`.
- `WAIT_START`: go to `WAIT_DONE` on `tx_busy`=1.
- `WAIT_DONE`, on `tx_busy`=0:
  - If `last_q`: `grant`←0, go to `ARB`.
  - Else: clear the gap counter, go to `NEXT`.
- `NEXT`:
  - If `req_valid[owner]` and `hold_q`=0: latch the byte and `req_last`, go to `ISSUE`.
  - If `req_valid[owner]`=0: increment the gap counter.
  - At `GAP_TIMEOUT`: `grant`←0, go to `ARB`. The packet is abandoned and `ptr` is kept, so the next search starts after the abandoning requester.
  - While `hold_q`=1 with valid high, the counter does not advance.
- Other requesters' `req_valid` is ignored while a grant is held. No byte is ever dropped or duplicated.
- `hold` is registered once into `hold_q`, and `tx_block`=`hold_q`.
  - Hold only gates new issues.
  - A byte already issued completes normally, because the transmitter ignores block outside its idle state.

## Timing
- `req_valid` sampled high in `ARB` at cycle 0 → `grant`, `tx_new_data`, `req_ready` all high in cycle 1. Latency is 1 cycle.
- Transmitter `busy` rises one cycle after `new_data`, i.e. `WAIT_START` lasts 1 cycle nominally.
- A byte occupies 3 controller cycles plus the transmitter's frame time. The next byte of a packet issues 2 cycles after `tx_busy` falls (`WAIT_DONE`→`NEXT`→`ISSUE`), with valid already high.
- All outputs are registered; no combinational path from inputs to outputs.
- Async reset mid-frame:
  - The controller returns to `ARB` immediately.
  - The shared transmitter must be reset by the same `rst` so the frame is aborted.
  - No `req_ready` is issued for the aborted byte's successors.
- Simultaneous `req_valid` from all requesters with `ptr`=2, NUM_REQ=4 → order of grants is 3,0,1,2.

## Structure
- Package `serial_tx_pkg`:
  - State enum: `ARB`, `ISSUE`, `WAIT_START`, `WAIT_DONE`, `NEXT`.
  - Byte width constant 8.
  - `REQ_IDX_W = $clog2(NUM_REQ)` helper.
- Sub-module `rr_pick`: combinational round-robin picker with inputs `req[NUM_REQ]` and `ptr`, outputs `idx` and `found`. It is reusable by later shared-peripheral arbiters.
- Bench instantiates the real `serial_tx` with CLK_PER_BIT=4.

## Test plan
- Single packet: requester 1 sends 0x55,0xA3(last) → two UART frames on `tx` with LSB-first bits of 0x55 then 0xA3; `req_ready[1]` pulses twice; `grant` returns to 0.
- Contention: all 4 requesters valid with 1-byte packets from reset (`ptr`=3) → grants in order 0,1,2,3, each bracketing exactly one frame.
- Packet lock: requester 0 sends a 3-byte packet while requester 2 is valid → all 3 bytes of requester 0 are sent before any byte of requester 2.
- Gap timeout, GAP_TIMEOUT=10: requester 1 sends a non-last byte then drops valid → `grant` clears exactly 10 cycles after entering `NEXT`; requester 2 is granted next.
- Hold: `hold` raised while in `ARB` with a request pending → no `tx_new_data` and `tx_block`=1; `hold` dropped → `tx_new_data` 2 cycles later.
- Reset mid-frame: assert `rst` during bit 4 → `grant`=0, `tx`=1 and `tx_new_data`=0 immediately; a fresh request after release transmits cleanly.

Source files
------------

// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_pkg
// Description : Shared types and helpers for the serial_tx arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_tx_pkg;

    localparam int c_byte_w = 8;

    typedef enum logic [2:0] {
        ARB        = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        NEXT       = 3'd4
    } arb_state_t;

    // Index width for a requester count; never below one bit.
    function automatic int req_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches from ptr+1 upward.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import serial_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = req_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // ptr + k stays below 2*NUM_REQ, so one subtraction wraps it.
            w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!found && req[w_pos]) begin
                idx   = w_pos;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx
// Description : 8N1 UART transmitter; block is honoured only while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       block,
    input  logic       new_data,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int c_ctr_w = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    tx_state_t          r_state, w_state_next;
    logic [c_ctr_w-1:0] r_ctr, w_ctr_next;
    logic [2:0]         r_bit, w_bit_next, w_nxt_bit;
    logic [7:0]         r_data, w_data_next;
    logic               r_tx, w_tx_next, r_busy, w_busy_next;
    logic               w_bit_end;

    assign w_nxt_bit = r_bit + 3'd1;
    assign w_bit_end = (r_ctr == c_ctr_w'(CLK_PER_BIT - 1));

    always_comb begin
        w_state_next = r_state;
        w_ctr_next   = r_ctr + 1'b1;
        w_bit_next   = r_bit;
        w_data_next  = r_data;
        w_tx_next    = r_tx;
        w_busy_next  = r_busy;
        case (r_state)
            S_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                w_ctr_next  = '0;
                if (new_data && !block) begin
                    w_data_next  = data;
                    w_state_next = S_START;
                    w_busy_next  = 1'b1;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_ctr_next   = '0;
                    w_bit_next   = 3'd0;
                    w_tx_next    = r_data[0];
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_ctr_next = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = w_nxt_bit;
                        w_tx_next  = r_data[w_nxt_bit];
                    end
                end
            end
            default: begin
                if (w_bit_end) begin
                    w_ctr_next   = '0;
                    w_busy_next  = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ctr   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ctr   <= w_ctr_next;
            r_bit   <= w_bit_next;
            r_data  <= w_data_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_arbiter
// Description : Packet-granular round-robin sharing of one serial_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_TIMEOUT = 1000,
    parameter int CTR_SIZE    = $clog2(GAP_TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [c_byte_w*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           grant,
    input  logic                         hold,
    output logic                         tx_new_data,
    output logic [c_byte_w-1:0]          tx_data,
    output logic                         tx_block,
    input  logic                         tx_busy
);

    localparam int c_idx_w = req_idx_w(NUM_REQ);

    arb_state_t          r_state, w_state_next;
    logic [NUM_REQ-1:0]  r_grant, w_grant_next, r_req_ready;
    logic [c_idx_w-1:0]  r_ptr, w_ptr_next, w_pick;
    logic [c_byte_w-1:0] r_tx_data, w_tx_data_next;
    logic [CTR_SIZE-1:0] r_gap, w_gap_next;
    logic                r_last, w_last_next, r_hold, r_new_data, w_found;
    logic [c_byte_w-1:0] w_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign w_bytes[g] = req_data[c_byte_w*g +: c_byte_w];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_ptr),
        .idx   (w_pick),
        .found (w_found)
    );

    // While a grant is held, r_ptr doubles as the owner index.
    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_ptr_next     = r_ptr;
        w_tx_data_next = r_tx_data;
        w_last_next    = r_last;
        w_gap_next     = r_gap;
        case (r_state)
            ARB: begin
                if (!r_hold && !tx_busy && w_found) begin
                    w_grant_next   = NUM_REQ'(1) << w_pick;
                    w_ptr_next     = w_pick;
                    w_tx_data_next = w_bytes[w_pick];
                    w_last_next    = req_last[w_pick];
                    w_state_next   = ISSUE;
                end
            end
            ISSUE: w_state_next = WAIT_START;
            WAIT_START: begin
                if (tx_busy) w_state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_last) begin
                        w_grant_next = '0;
                        w_state_next = ARB;
                    end else begin
                        w_gap_next   = '0;
                        w_state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                if (req_valid[r_ptr]) begin
                    if (!r_hold) begin
                        w_tx_data_next = w_bytes[r_ptr];
                        w_last_next    = req_last[r_ptr];
                        w_state_next   = ISSUE;
                    end
                end else begin
                    w_gap_next = r_gap + 1'b1;
                    if (w_gap_next == CTR_SIZE'(GAP_TIMEOUT)) begin
                        w_grant_next = '0;
                        w_state_next = ARB;
                    end
                end
            end
            default: begin
                w_grant_next = '0;
                w_state_next = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB;
            r_grant     <= '0;
            r_ptr       <= c_idx_w'(NUM_REQ - 1);
            r_tx_data   <= '0;
            r_last      <= 1'b0;
            r_gap       <= '0;
            r_hold      <= 1'b0;
            r_new_data  <= 1'b0;
            r_req_ready <= '0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_ptr       <= w_ptr_next;
            r_tx_data   <= w_tx_data_next;
            r_last      <= w_last_next;
            r_gap       <= w_gap_next;
            r_hold      <= hold;
            r_new_data  <= (w_state_next == ISSUE);
            r_req_ready <= (w_state_next == ISSUE) ? w_grant_next : '0;
        end
    end

    assign grant       = r_grant;
    assign req_ready   = r_req_ready;
    assign tx_new_data = r_new_data;
    assign tx_data     = r_tx_data;
    assign tx_block    = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_arbiter
// Description : Scoreboard bench for serial_tx_arbiter driving a real serial_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int GAP_TIMEOUT = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*NUM_REQ-1:0] req_data;
    logic                 hold, tx_new_data, tx_block, tx_busy, tx;
    logic [7:0]           tx_data;

    int         checks   = 0;
    int         failures = 0;
    logic [11:0] exp_iss[$];
    logic [7:0]  exp_uart[$];
    logic [8:0]  src_mem [NUM_REQ][16];
    int          src_rd  [NUM_REQ];
    int          src_wr  [NUM_REQ];
    int          rdy_cnt [NUM_REQ];

    always #5 clk = ~clk;

    serial_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .hold        (hold),
        .tx_new_data (tx_new_data),
        .tx_data     (tx_data),
        .tx_block    (tx_block),
        .tx_busy     (tx_busy)
    );

    serial_tx #(.CLK_PER_BIT(4)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .block    (tx_block),
        .new_data (tx_new_data),
        .data     (tx_data),
        .tx       (tx),
        .busy     (tx_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, want);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no event within cycle budget, required event", name);
    endtask

    task automatic queue_byte(input int r, input logic [7:0] b, input logic last, input logic on_wire);
        src_mem[r][src_wr[r]] = {last, b};
        src_wr[r]++;
        exp_iss.push_back({r[3:0], b});
        if (on_wire) exp_uart.push_back(b);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(exp_iss.size() == 0 && exp_uart.size() == 0 && grant == '0 && tx_busy == 1'b0)
               && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) timeout_fail({name, "_drain"});
        chk({name, "_grant_idle"}, grant, 0);
    endtask

    task automatic wait_issue(input string name);
        int n;
        n = 0;
        while (tx_new_data !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx_new_data !== 1'b1) timeout_fail(name);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requester models: present the queued byte until it is accepted.
    initial begin : driver
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) src_rd[i]++;
                if (src_rd[i] != src_wr[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
                    req_last[i]        = src_mem[i][src_rd[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin : issue_mon
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!rst && (tx_new_data || req_ready != '0)) begin
                if (!tx_new_data) begin
                    chk("ready_without_issue", req_ready, 0);
                end else if (exp_iss.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: got data %0h grant %b, required no issue", tx_data, grant);
                end else begin
                    e = exp_iss.pop_front();
                    chk("issue_grant", grant, 32'd1 << e[11:8]);
                    chk("issue_ready", req_ready, 32'd1 << e[11:8]);
                    chk("issue_data", tx_data, e[7:0]);
                end
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cnt[i]++;
            end
        end
    end

    // Frames disturbed by reset are discarded rather than scored.
    initial begin : uart_mon
        logic [7:0] b;
        logic       ab, stopb;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                ab = 1'b0;
                b  = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) begin @(negedge clk); if (rst) ab = 1'b1; end
                    b[i] = tx;
                end
                repeat (4) begin @(negedge clk); if (rst) ab = 1'b1; end
                stopb = tx;
                if (!ab) begin
                    if (exp_uart.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got byte %0h, required no frame", b);
                    end else begin
                        chk("uart_byte", b, exp_uart.pop_front());
                        chk("uart_stop", stopb, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int k;
        rst  = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_rd[i]  = 0;
            src_wr[i]  = 0;
            rdy_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_grant", grant, 0);
        chk("reset_ready", req_ready, 0);
        chk("reset_new_data", tx_new_data, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_tx_block", tx_block, 0);
        hold = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Single two-byte packet from requester 1.
        queue_byte(1, 8'h55, 1'b0, 1'b1);
        queue_byte(1, 8'hA3, 1'b1, 1'b1);
        drain("single");
        chk("single_ready_pulses", rdy_cnt[1], 2);

        // All four contend right after reset: order 0,1,2,3.
        pulse_reset();
        queue_byte(0, 8'h10, 1'b1, 1'b1);
        queue_byte(1, 8'h21, 1'b1, 1'b1);
        queue_byte(2, 8'h32, 1'b1, 1'b1);
        queue_byte(3, 8'h43, 1'b1, 1'b1);
        drain("contention");

        // Requester 0 keeps the grant for its whole packet.
        queue_byte(0, 8'hC1, 1'b0, 1'b1);
        queue_byte(0, 8'hC2, 1'b0, 1'b1);
        queue_byte(0, 8'hC3, 1'b1, 1'b1);
        queue_byte(2, 8'hE7, 1'b1, 1'b1);
        drain("lock");

        // Requester 1 stalls mid-packet; requester 2 follows the timeout.
        @(posedge clk); #1;
        queue_byte(1, 8'h5A, 1'b0, 1'b1);
        queue_byte(2, 8'h6B, 1'b1, 1'b1);
        n = 0;
        while (tx_busy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (tx_busy !== 1'b1) timeout_fail("gap_busy_rise");
        n = 0;
        while (tx_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (tx_busy !== 1'b0) timeout_fail("gap_busy_fall");
        chk("gap_grant_held", grant, 4'b0010);
        k = 0;
        while (grant !== '0 && k < 50) begin @(negedge clk); k++; end
        chk("gap_timeout_cycles", k, 1 + GAP_TIMEOUT);
        drain("gap");

        // Hold parks a pending request until released.
        @(posedge clk); #1 hold = 1'b1;
        repeat (2) @(negedge clk);
        chk("hold_block", tx_block, 1);
        @(posedge clk); #1;
        queue_byte(3, 8'h99, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_no_issue", tx_new_data, 0);
        end
        @(posedge clk); #1 hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold_release_cycle1", tx_new_data, 0);
        chk("hold_release_block", tx_block, 0);
        @(negedge clk);
        chk("hold_release_cycle2", tx_new_data, 1);
        drain("hold");

        // Reset during data bit 4 aborts the frame.
        @(posedge clk); #1;
        queue_byte(0, 8'h2C, 1'b1, 1'b0);
        wait_issue("rst_issue");
        repeat (22) @(negedge clk);
        chk("rst_tx_bit4", tx, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_tx_line", tx, 1);
        chk("rst_new_data", tx_new_data, 0);
        chk("rst_ready", req_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_idle_tx", tx, 1);
        @(posedge clk); #1;
        queue_byte(2, 8'hB6, 1'b1, 1'b1);
        drain("after_reset");

        chk("exp_issue_empty", exp_iss.size(), 0);
        chk("exp_uart_empty", exp_uart.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
